// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add scheduler.
// Optional subtract support in the users of this package is enabled by
// defining SERIAL_SUB_EN.
package serial_add_pkg;

  localparam int SERIAL_ADD_DEF_N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sas_state_t;

  typedef logic req_id_t;

  function automatic logic [1:0] id_to_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/serial_fa_slice.sv
// One-bit full-adder slice with its carry flop. The carry is only updated
// while en is high so the final carry-out holds after the last bit.
// preset wins over clear so a subtract can start with carry = 1.
module serial_fa_slice (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  input  logic preset,
  input  logic a_bit,
  input  logic b_bit,
  output logic s_bit,
  output logic carry
);

  assign s_bit = a_bit ^ b_bit ^ carry;

  // Carry register: start-of-operation init, then majority update per bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry <= 1'b0;
    end else if (preset) begin
      carry <= 1'b1;
    end else if (clear) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    end
  end

endmodule

// File: rtl/serial_add_sched.sv
// Two-requester round-robin scheduler in front of a bit-serial adder.
// Define SERIAL_SUB_EN to add the per-requester op port (1 = a - b).
//
// state | meaning
// IDLE  | waiting for a request; grants one requester round-robin
// SHIFT | one operand bit per clock, LSB first, N clocks
// DONE  | result presented on res_*; held until res_ready
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int N = SERIAL_ADD_DEF_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
`ifdef SERIAL_SUB_EN
  input  logic [1:0]   op,
`endif
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_sum,
  output logic         res_cout,
  output logic         res_id,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  sas_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  req_id_t       last_grant;
  req_id_t       grant;
  req_id_t       id_reg;
  logic [N-1:0]  a_reg, b_reg;
  logic          accept;
  logic          shift_en;
  logic          sub_sel;
  logic          b_bit;
  logic          s_bit;

`ifdef SERIAL_SUB_EN
  logic sub_reg;

  assign sub_sel = grant ? op[1] : op[0];
  assign b_bit   = b_reg[0] ^ sub_reg;

  // Operation kind is captured with the operands and held for the whole op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_reg <= 1'b0;
    end else if (accept) begin
      sub_reg <= sub_sel;
    end
  end
`else
  assign sub_sel = 1'b0;
  assign b_bit   = b_reg[0];
`endif

  // Round-robin arbitration: on a tie the requester not granted last wins.
  always_comb begin
    if (req_valid == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = req_valid[1];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; req_ready is held low during reset.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (reset && (req_valid != 2'b00)) begin
          req_ready = id_to_onehot(grant);
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res_id    = id_reg;

  // Operand capture on accept, then LSB-first shifting; sum fills from the MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      last_grant <= 1'b1;
      id_reg     <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      res_sum    <= '0;
    end else if (accept) begin
      cnt        <= '0;
      last_grant <= grant;
      id_reg     <= grant;
      a_reg      <= grant ? a1 : a0;
      b_reg      <= grant ? b1 : b0;
    end else if (shift_en) begin
      cnt     <= cnt + CW'(1);
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      res_sum <= (res_sum >> 1) | (N'(s_bit) << (N - 1));
    end
  end

  serial_fa_slice u_fa (
    .clk    (clk),
    .reset  (reset),
    .en     (shift_en),
    .clear  (accept),
    .preset (accept & sub_sel),
    .a_bit  (a_reg[0]),
    .b_bit  (b_bit),
    .s_bit  (s_bit),
    .carry  (res_cout)
  );

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched (N=4). Subtract vectors run when SERIAL_SUB_EN
// is defined for both the bench and the design.
module tb_serial_add_sched;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] a0, b0, a1, b1;
  logic [1:0]   op;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_sum;
  logic         res_cout;
  logic         res_id;
  logic         busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  int acc_cyc[$];
  int acc_id[$];

  // Behavioural model: outstanding op, its expected result and timing.
  logic         m_busy, m_done, m_last, m_id;
  logic [N-1:0] m_sum;
  logic         m_cout;
  int           m_acc;

  serial_add_sched #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
`ifdef SERIAL_SUB_EN
    .op        (op),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic winner(input logic [1:0] v, input logic last);
    if (v == 2'b11) return !last;
    return v[1];
  endfunction

  // Model update on each rising edge (inputs are stable mid-cycle).
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_last = 1'b1;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (req_valid != 2'b00) begin
          logic         w;
          logic         sub;
          logic [N-1:0] aa, bb;
          logic [N:0]   full;
          w   = winner(req_valid, m_last);
          aa  = w ? a1 : a0;
          bb  = w ? b1 : b0;
          sub = 1'b0;
`ifdef SERIAL_SUB_EN
          sub = op[w];
`endif
          if (sub) bb = ~bb;
          full   = {1'b0, aa} + {1'b0, bb} + {{N{1'b0}}, sub};
          m_sum  = full[N-1:0];
          m_cout = full[N];
          m_id   = w;
          m_last = w;
          m_busy = 1'b1;
          m_acc  = cyc;
        end
      end else if (m_done) begin
        if (res_ready) begin
          m_busy = 1'b0;
          m_done = 1'b0;
        end
      end else if (cyc - m_acc == N) begin
        m_done = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_sum", res_sum, 0);
      chk("rst_res_cout", res_cout, 0);
      chk("rst_res_id", res_id, 0);
    end else begin
      logic [1:0] exp_rr;
      exp_rr = 2'b00;
      if (!m_busy && req_valid != 2'b00)
        exp_rr = winner(req_valid, m_last) ? 2'b10 : 2'b01;
      chk("req_ready", req_ready, exp_rr);
      chk("busy", busy, m_busy);
      chk("res_valid", res_valid, m_done);
      if (m_done) begin
        chk("res_sum", res_sum, m_sum);
        chk("res_cout", res_cout, m_cout);
        chk("res_id", res_id, m_id);
      end
      if ((req_valid & req_ready) != 2'b00) begin
        acc_cyc.push_back(cyc);
        acc_id.push_back(req_ready[1] ? 1 : 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name, output int vcyc);
    bit seen;
    seen = 1'b0;
    vcyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1'b1;
        vcyc = cyc;
      end
    end
    chk({name, "_timeout"}, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vc;
    int base;
    reset     = 1'b0;
    req_valid = 2'b00;
    res_ready = 1'b0;
    op        = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #3;
    tick(2);
    req_valid = 2'b11;
    @(negedge clk);
    chk("lit_rst_ready_gated", req_ready, 2'b00);
    chk("lit_rst_busy", busy, 0);
    tick(1);
    req_valid = 2'b00;
    reset = 1'b1;
    tick(1);

    // 1101 + 1011 = 1_1000
    a0 = 4'b1101; b0 = 4'b1011; req_valid = 2'b01;
    tick(1);
    req_valid = 2'b00;
    wait_valid("t31", vc);
    chk("lit_t31_latency", vc - acc_cyc[$] - 1, 4);
    chk("lit_t31_sum", res_sum, 4'b1000);
    chk("lit_t31_cout", res_cout, 1);
    chk("lit_t31_id", res_id, 0);

    // Result held while the consumer stalls; requests are not granted.
    @(posedge clk); #2;
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("lit_hold_valid", res_valid, 1);
      chk("lit_hold_sum", res_sum, 4'b1000);
      chk("lit_hold_ready", req_ready, 2'b00);
    end
    @(posedge clk); #2;
    req_valid = 2'b00;
    res_ready = 1'b1;
    @(negedge clk);
    chk("lit_release_still_done", res_valid, 1);
    @(negedge clk);
    chk("lit_release_idle", busy, 0);
    chk("lit_release_valid", res_valid, 0);
    tick(1);

    // 1111 + 0001 wraps to 0000 with carry out.
    a0 = 4'b1111; b0 = 4'b0001; req_valid = 2'b01;
    tick(1);
    req_valid = 2'b00;
    wait_valid("t36", vc);
    chk("lit_t36_sum", res_sum, 4'b0000);
    chk("lit_t36_cout", res_cout, 1);
    tick(1);

    // Fresh reset, both requesting: requester 0 first, then 1.
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    base = acc_cyc.size();
    a0 = 4'b0011; b0 = 4'b0100; a1 = 4'b1001; b1 = 4'b1000;
    req_valid = 2'b11;
    wait_valid("t32a", vc);
    chk("lit_t32a_id", res_id, 0);
    chk("lit_t32a_sum", res_sum, 4'b0111);
    chk("lit_t32a_cout", res_cout, 0);
    @(posedge clk); #2;
    wait_valid("t32b", vc);
    chk("lit_t32b_id", res_id, 1);
    chk("lit_t32b_sum", res_sum, 4'b0001);
    chk("lit_t32b_cout", res_cout, 1);
    @(posedge clk); #2;
    req_valid = 2'b00;
    chk("lit_t32_acc_count", acc_cyc.size() >= base + 2, 1);
    if (acc_cyc.size() >= base + 2) begin
      chk("lit_t32_first_id", acc_id[base], 0);
      chk("lit_t32_second_id", acc_id[base + 1], 1);
      chk("lit_t32_spacing", acc_cyc[base + 1] - acc_cyc[base], 6);
    end
    tick(2);

    // Reset two edges into SHIFT, then a clean op from requester 1.
    a0 = 4'b0101; b0 = 4'b0011; req_valid = 2'b01;
    tick(1);
    req_valid = 2'b00;
    tick(2);
    reset = 1'b0;
    #1;
    chk("lit_t34_busy", busy, 0);
    chk("lit_t34_valid", res_valid, 0);
    chk("lit_t34_sum", res_sum, 0);
    chk("lit_t34_cout", res_cout, 0);
    chk("lit_t34_id", res_id, 0);
    a1 = 4'b0110; b1 = 4'b0111; req_valid = 2'b10;
    #1;
    chk("lit_t34_ready", req_ready, 2'b00);
    tick(1);
    reset = 1'b1;
    tick(1);
    req_valid = 2'b00;
    wait_valid("t34", vc);
    chk("lit_t34n_sum", res_sum, 4'b1101);
    chk("lit_t34n_cout", res_cout, 0);
    chk("lit_t34n_id", res_id, 1);
    tick(1);

`ifdef SERIAL_SUB_EN
    op = 2'b10;
    a1 = 4'b1101; b1 = 4'b1011; req_valid = 2'b10;
    tick(1);
    req_valid = 2'b00;
    wait_valid("t35a", vc);
    chk("lit_t35a_sum", res_sum, 4'b0010);
    chk("lit_t35a_cout", res_cout, 1);
    tick(1);
    a1 = 4'b0011; b1 = 4'b0101; req_valid = 2'b10;
    tick(1);
    req_valid = 2'b00;
    wait_valid("t35b", vc);
    chk("lit_t35b_sum", res_sum, 4'b1110);
    chk("lit_t35b_cout", res_cout, 0);
    tick(1);
    op = 2'b00;
`endif

    tick(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_add_sched.md
SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

Interface
REQ-001 SHALL have parameter N, default 4, operand/sum width in bits (N >= 1).
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 2, per-requester operation request.
REQ-005 SHALL have port req_ready, output, 2, per-requester accept; transfer when req_valid[i] && req_ready[i].
REQ-006 SHALL have ports a0, b0, input, N each, requester-0 operands.
REQ-007 SHALL have ports a1, b1, input, N each, requester-1 operands.
REQ-008 SHALL have port op, input, 2, per-requester op bit (1 = subtract); present only with SERIAL_SUB_EN.
REQ-009 SHALL have port res_valid, output, 1, result available.
REQ-010 SHALL have port res_ready, input, 1, result consumer accept.
REQ-011 SHALL have port res_sum, output, N, result bits.
REQ-012 SHALL have port res_cout, output, 1, final carry-out.
REQ-013 SHALL have port res_id, output, 1, index of requester owning the result.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 In IDLE, SHALL grant one requester round-robin: the requester not granted last wins a tie; a lone request wins regardless.
REQ-017 req_ready SHALL be one-hot to the granted requester in IDLE with req_valid high, else 2'b00.
REQ-018 On the accept edge, SHALL latch a, b, op, and id of the granted requester, clear the carry register, set the bit counter to 0, update last-grant, and enter SHIFT.
REQ-019 In SHIFT, SHALL process one bit per clock LSB-first: sum bit = a^b^c, carry updated, result shifted into res_sum from the MSB end.
REQ-020 After the N-th SHIFT edge, SHALL enter DONE with res_valid = 1; res_valid SHALL rise exactly N edges after the accept edge.
REQ-021 In DONE, res_sum/res_cout/res_id SHALL be held stable until res_valid && res_ready, then return to IDLE.
REQ-022 SHALL not accept a new request in SHIFT or DONE; minimum spacing between accepts is N+2 cycles.
REQ-023 Requests deasserted while the block is busy SHALL be ignored; no request is queued.
REQ-024 res_cout SHALL equal bit N of the (N+1)-bit true sum; overflow wraps to N bits.

Reset
REQ-025 Reset low SHALL force IDLE asynchronously, at any state including mid-SHIFT, discarding the operation in flight.
REQ-026 Reset values: req_ready 0, res_valid 0, res_sum 0, res_cout 0, res_id 0, busy 0, counter 0, carry 0, last-grant 1 (requester 0 wins the first tie).

Configuration
REQ-027 Macro SERIAL_SUB_EN: when defined, op port exists; op = 1 SHALL invert b bits and preset carry to 1 (a - b; res_cout = 1 means no borrow).
REQ-028 Without SERIAL_SUB_EN, op port SHALL be absent and every operation SHALL be addition.

Structure
REQ-029 Shared package serial_add_pkg SHALL hold the FSM state enum, requester-id typedef, and default width constant.
REQ-030 Bit-serial full-adder slice with carry flop SHALL be a sub-module serial_fa_slice (inputs a_bit, b_bit, clear, preset; outputs s_bit, carry).

Verification
REQ-031 N=4, req_valid=01, a0=1101, b0=1011 -> res_valid rises 4 edges after accept; res_sum=1000, res_cout=1, res_id=0.
REQ-032 Both req_valid=11 from reset, res_ready=1 -> first result res_id=0, second res_id=1; accepts spaced 6 cycles.
REQ-033 res_ready=0 for 10 cycles in DONE -> res_valid and res_sum held; req_ready stays 00; release -> IDLE next edge.
REQ-034 Reset low 2 edges into SHIFT -> all outputs at reset values immediately; next request completes correctly.
REQ-035 SERIAL_SUB_EN, op[1]=1, a1=1101, b1=1011 -> res_sum=0010, res_cout=1; a1=0011, b1=0101 -> res_sum=1110, res_cout=0.
REQ-036 a0=1111, b0=0001 addition -> res_sum=0000, res_cout=1 (wrap).
